// File: rtl/prio_rr_arb.sv
// Mixed strict-priority / round-robin arbiter with starvation guard and grant lock.
// Latency: 1 cycle from req/lock sample to registered gnt; no comb path req->gnt.
// Backpressure: none; requesters hold req high until granted, grant drops when req drops.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   req[N-1:0]    level request vector; [N-1:N_RR] strict priority, [N_RR-1:0] round-robin
//   lock          keep the current grant while its holder keeps requesting
//   gnt[N-1:0]    one-hot registered grant (all zero = idle)
//   gnt_vld       OR of gnt
//   gnt_id        binary index of the granted requester, 0 when idle
module prio_rr_arb #(
  parameter int N_PRIO       = 1,
  parameter int N_RR         = 2,
  parameter int STARVE_LIMIT = 8,
  localparam int N   = N_PRIO + N_RR,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           lock,
  output logic [N-1:0]   gnt,
  output logic           gnt_vld,
  output logic [IDW-1:0] gnt_id
);

  localparam int RPW = (N_RR > 1) ? $clog2(N_RR) : 1;
  localparam int SCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SCW-1:0] SC_MAX = SCW'(STARVE_LIMIT);
  localparam logic [RPW-1:0] RP_RST = RPW'(N_RR - 1);

  logic [RPW-1:0] rr_ptr;
  logic [SCW-1:0] starve_cnt;

  logic           rr_any;
  logic           prio_any;
  logic [IDW-1:0] prio_idx;
  logic           rr_found;
  logic [IDW-1:0] rr_idx;
  int             rr_j;

  logic           hold;
  logic           force_rr;
  logic           nxt_vld;
  logic           nxt_is_rr;
  logic [IDW-1:0] nxt_id;

  // Candidate selection for both request classes.
  always_comb begin
    rr_any   = |req[N_RR-1:0];
    prio_any = 1'b0;
    prio_idx = '0;
    // Ascending scan: the last hit is the highest set priority index.
    for (int i = N_RR; i < N; i++) begin
      if (req[IDW'(i)]) begin
        prio_any = 1'b1;
        prio_idx = IDW'(i);
      end
    end

    // Circular search starting just after the last round-robin winner.
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_j     = 0;
    for (int k = 1; k <= N_RR; k++) begin
      rr_j = int'(rr_ptr) + k;
      if (rr_j >= N_RR) rr_j = rr_j - N_RR;
      if (!rr_found && req[IDW'(rr_j)]) begin
        rr_found = 1'b1;
        rr_idx   = IDW'(rr_j);
      end
    end
  end

  // Next-grant precedence: hold, forced round-robin, priority, round-robin.
  always_comb begin
    hold     = lock && gnt_vld && req[gnt_id];
    force_rr = (STARVE_LIMIT > 0) && (starve_cnt == SC_MAX) && rr_any;

    nxt_vld   = 1'b0;
    nxt_is_rr = 1'b0;
    nxt_id    = '0;
    if (hold) begin
      nxt_vld   = 1'b1;
      nxt_id    = gnt_id;
      nxt_is_rr = (int'(gnt_id) < N_RR);
    end else if (force_rr) begin
      nxt_vld   = 1'b1;
      nxt_id    = rr_idx;
      nxt_is_rr = 1'b1;
    end else if (prio_any) begin
      nxt_vld   = 1'b1;
      nxt_id    = prio_idx;
      nxt_is_rr = 1'b0;
    end else if (rr_found) begin
      nxt_vld   = 1'b1;
      nxt_id    = rr_idx;
      nxt_is_rr = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt        <= '0;
      gnt_vld    <= 1'b0;
      gnt_id     <= '0;
      // Pointer starts on the last slot so index 0 wins the first round.
      rr_ptr     <= RP_RST;
      starve_cnt <= '0;
    end else begin
      gnt_vld <= nxt_vld;
      gnt_id  <= nxt_vld ? nxt_id : '0;
      gnt     <= nxt_vld ? (N'(1) << nxt_id) : '0;

      if (nxt_vld && nxt_is_rr) rr_ptr <= RPW'(nxt_id);

      // Counts priority grants taken while round-robin traffic waits; locked
      // bursts keep counting and saturate so force fires once the lock ends.
      // A no-grant cycle implies no round-robin request, so clearing is correct.
      if (nxt_vld && !nxt_is_rr && rr_any) begin
        if (starve_cnt != SC_MAX) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prio_rr_arb.sv
// Bench for prio_rr_arb: three configurations (default, wide 2+4 with limit 3,
// and guard disabled) driven with directed sequences and random traffic, each
// compared cycle by cycle against an integer model of the arbitration rules.
module tb_prio_rr_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lock;
  logic [2:0] req_a;
  logic [5:0] req_b;

  logic [2:0] gnt_a, gnt_c;
  logic [5:0] gnt_b;
  logic       vld_a, vld_b, vld_c;
  logic [1:0] id_a, id_c;
  logic [2:0] id_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model configuration and state per instance (0=a, 1=b, 2=c).
  int    p_np[3] = '{1, 2, 1};
  int    p_nr[3] = '{2, 4, 2};
  int    p_sl[3] = '{8, 3, 0};
  string nm[3]   = '{"a", "b", "c"};
  int    m_vld[3];
  int    m_id[3];
  int    m_last[3];
  int    m_run[3];

  always #5 clk = ~clk;

  prio_rr_arb #(.N_PRIO(1), .N_RR(2), .STARVE_LIMIT(8)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .lock(lock),
    .gnt(gnt_a), .gnt_vld(vld_a), .gnt_id(id_a));

  prio_rr_arb #(.N_PRIO(2), .N_RR(4), .STARVE_LIMIT(3)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .lock(lock),
    .gnt(gnt_b), .gnt_vld(vld_b), .gnt_id(id_b));

  prio_rr_arb #(.N_PRIO(1), .N_RR(2), .STARVE_LIMIT(0)) dut_c (
    .clk(clk), .rst(rst), .req(req_a), .lock(lock),
    .gnt(gnt_c), .gnt_vld(vld_c), .gnt_id(id_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_vld[k]  = 0;
      m_id[k]   = 0;
      m_last[k] = p_nr[k] - 1;
      m_run[k]  = 0;
    end
  endtask

  // One arbitration decision from the rules: hold, starvation force,
  // highest priority requester, then next round-robin requester after the last.
  task automatic model_step(input int k);
    logic [7:0] r;
    int  n, nr, pick, top, nid;
    bit  nv, rr_pend;
    r  = (k == 1) ? {2'b00, req_b} : {5'b00000, req_a};
    nr = p_nr[k];
    n  = p_np[k] + nr;
    rr_pend = 0;
    for (int i = 0; i < nr; i++) if (r[i]) rr_pend = 1;
    pick = -1;
    for (int d = 1; d <= nr; d++) begin
      int c;
      c = (m_last[k] + d) % nr;
      if (pick < 0 && r[c]) pick = c;
    end
    top = -1;
    for (int i = n - 1; i >= nr; i--) if (top < 0 && r[i]) top = i;

    nv  = 1;
    nid = 0;
    if (lock && m_vld[k] != 0 && r[m_id[k]]) nid = m_id[k];
    else if (p_sl[k] > 0 && m_run[k] >= p_sl[k] && rr_pend) nid = pick;
    else if (top >= 0) nid = top;
    else if (pick >= 0) nid = pick;
    else nv = 0;

    if (nv && nid < nr) begin
      m_last[k] = nid;
      m_run[k]  = 0;
    end else if (nv && rr_pend) begin
      m_run[k]++;
    end else begin
      m_run[k] = 0;
    end
    m_vld[k] = nv ? 1 : 0;
    m_id[k]  = nv ? nid : 0;
  endtask

  task automatic check_all();
    logic [31:0] g, v, d, eg;
    for (int k = 0; k < 3; k++) begin
      g  = (k == 0) ? 32'(gnt_a) : (k == 1) ? 32'(gnt_b) : 32'(gnt_c);
      v  = (k == 0) ? 32'(vld_a) : (k == 1) ? 32'(vld_b) : 32'(vld_c);
      d  = (k == 0) ? 32'(id_a)  : (k == 1) ? 32'(id_b)  : 32'(id_c);
      eg = (m_vld[k] != 0) ? (32'd1 << m_id[k]) : 32'd0;
      check($sformatf("%s.gnt", nm[k]), g, eg);
      check($sformatf("%s.gnt_vld", nm[k]), v, 32'(m_vld[k]));
      check($sformatf("%s.gnt_id", nm[k]), d, 32'(m_id[k]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) model_step(k);
    check_all();
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".a"}, {29'd0, gnt_a, vld_a, id_a}, 32'd0);
    check({tag, ".b"}, {22'd0, gnt_b, vld_b, id_b}, 32'd0);
    check({tag, ".c"}, {29'd0, gnt_c, vld_c, id_c}, 32'd0);
  endtask

  logic [5:0] wide_g[5] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b000001};

  initial begin
    lock  = 1'b0;
    req_a = '0;
    req_b = '0;
    #1 rst = 1'b1;
    #11;
    check_idle("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Starvation guard: 8 priority grants then one forced round-robin grant.
    req_a = 3'b111;
    req_b = 6'b011111;
    for (int i = 1; i <= 18; i++) begin
      cycle();
      check("starve.a", 32'(gnt_a), (i == 9) ? 32'd1 : (i == 18) ? 32'd2 : 32'd4);
      check("starve.c", 32'(gnt_c), 32'd4);
    end

    // Reset pulsed between edges clears outputs without a clock.
    #3 rst = 1'b1;
    #1;
    check_idle("midrst");
    #1 rst = 1'b0;
    model_reset();
    cycle();
    check("post_rst.a", 32'(gnt_a), 32'd4);
    check("post_rst.b", 32'(gnt_b), 32'h10);
    check("post_rst.b_id", 32'(id_b), 32'd4);

    // Round-robin walk in the wide config, alternation in the default one.
    req_a = 3'b011;
    req_b = 6'b001111;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("wide.gnt", 32'(gnt_b), 32'(wide_g[i]));
      check("wide.id", 32'(id_b), 32'(i % 4));
      check("alt.a", 32'(gnt_a), (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    // Lock holds the round-robin winner, then releases when its req drops.
    lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("lock.hold", 32'(gnt_a), 32'd1);
    end
    req_a = 3'b010;
    cycle();
    check("lock.drop", 32'(gnt_a), 32'd2);
    check("lock.drop_id", 32'(id_a), 32'd1);
    req_a = 3'b000;
    lock  = 1'b0;
    cycle();
    req_a = 3'b111;
    lock  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      check("lock.burst", 32'(gnt_a), 32'd4);
    end
    lock = 1'b0;
    cycle();
    check("lock.force", 32'(gnt_a), 32'd1);

    // Idle gap, then round-robin resumes opposite the last winner.
    req_a = 3'b000;
    req_b = 6'b000000;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("idle.vld", 32'(vld_a), 32'd0);
    end
    req_a = 3'b011;
    cycle();
    check("resume.a", 32'(gnt_a), 32'd2);

    // Random traffic with sticky requests so locks and bursts occur.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) req_a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) req_b = 6'($urandom_range(0, 63));
      lock = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
